// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned INSTR_BYTES  = 4;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue between fetch and decode: DEPTH entries of {pc, instr}.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           push_ok;
  logic           pop_ok;

  // Status flags and qualified push/pop strobes.
  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    head    = mem[rd_ptr];
  end

  // Storage, pointers and occupancy; flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Pipelined instruction fetch front end: issues in-order imem requests with
// up to MAX_OUTST in flight, buffers returned words in a DEPTH-entry queue and
// flushes both the queue and in-flight responses on redirect.
// XLEN must match fetch_pkg::XLEN_DEFAULT (width of the queue entry fields).
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEFAULT,
  parameter int unsigned     DEPTH     = 4,
  parameter int unsigned     MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_instr
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned OW = $clog2(MAX_OUTST+1);
  localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  logic            active;
  logic [XLEN-1:0] fetch_pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   outstanding_nxt;
  logic [OW-1:0]   discard;
  logic [XLEN-1:0] pc_fifo [MAX_OUTST];
  logic [PW-1:0]   pc_wr;
  logic [PW-1:0]   pc_rd;

  logic            credit_ok;
  logic            req_accept;
  logic            rsp_ok;
  logic            q_push;
  logic            q_pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    q_head;
  logic [CW-1:0]   q_count;
  logic            q_full;
  logic            q_empty;
  logic [XLEN-1:0] redirect_target;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  // Request/response/decode handshakes and next outstanding count.
  always_comb begin
    // Every accepted request owns a queue slot, so the queue can never overflow.
    credit_ok       = (32'(q_count) + 32'(outstanding)) < DEPTH;
    imem_req_valid  = active && !redirect_valid
                      && (outstanding < OW'(MAX_OUTST)) && credit_ok;
    imem_req_addr   = fetch_pc;
    req_accept      = imem_req_valid && imem_req_ready;
    rsp_ok          = imem_rsp_valid && (outstanding != '0);
    // A response in the redirect cycle belongs to the old path and is dropped.
    q_push          = rsp_ok && (discard == '0) && !redirect_valid;
    dec_valid       = !q_empty && !redirect_valid;
    q_pop           = dec_valid && dec_ready;
    push_entry      = '{pc: pc_fifo[pc_rd], instr: imem_rsp_data};
    dec_pc          = q_head.pc;
    dec_instr       = q_head.instr;
    redirect_target = redirect_pc & ~XLEN'(INSTR_BYTES - 1);
    outstanding_nxt = outstanding;
    if (req_accept && !rsp_ok) begin
      outstanding_nxt = outstanding + 1'b1;
    end else if (!req_accept && rsp_ok) begin
      outstanding_nxt = outstanding - 1'b1;
    end
  end

  // Requests start the cycle after reset is released.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active <= 1'b0;
    end else begin
      active <= 1'b1;
    end
  end

  // Fetch PC: redirect target wins, otherwise advance one word per accept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
    end else if (req_accept) begin
      fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
    end
  end

  // In-flight bookkeeping; on redirect everything still in flight is marked for discard.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        // discard is always a subset of outstanding, so earlier discards carry over.
        discard <= outstanding_nxt;
      end else if (rsp_ok && (discard != '0)) begin
        discard <= discard - 1'b1;
      end
    end
  end

  // PCs of in-flight requests, retired in order as responses arrive (dropped or not).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_fifo <= '{default: '0};
      pc_wr   <= '0;
      pc_rd   <= '0;
    end else begin
      if (req_accept) begin
        pc_fifo[pc_wr] <= fetch_pc;
        pc_wr          <= ptr_next(pc_wr);
      end
      if (rsp_ok) begin
        pc_rd <= ptr_next(pc_rd);
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk      (clk),
    .rstn     (rstn),
    .push     (q_push),
    .push_data(push_entry),
    .pop      (q_pop),
    .flush    (redirect_valid),
    .head     (q_head),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

  rsp_without_request: assert property (@(posedge clk) disable iff (!rstn)
    imem_rsp_valid |-> (outstanding != '0));

  queue_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(q_push && q_full && !q_pop));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a fixed-latency instruction memory model.
module tb_fetch_queue;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam logic [31:0] KEY       = 32'h1357_9BDF;

  logic        clk;
  logic        rstn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;

  fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .MAX_OUTST(MAX_OUTST),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_pc        (dec_pc),
    .dec_instr     (dec_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          lat     = 1;
  int          cyc     = 0;
  int          out_m   = 0;
  int          max_out = 0;
  int          acc_n   = 0;
  logic [31:0] mq_addr [$];
  int          mq_due  [$];
  logic [31:0] acc_addr[$];
  logic [31:0] pop_pc  [$];
  logic [31:0] pop_ins [$];
  int          pop_cyc [$];
  logic        s_req_valid;
  logic        s_dec_valid;
  logic [31:0] s_req_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: present due response, sample outputs, log handshakes.
  task automatic tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq_addr[0] ^ KEY;
    end
    #1;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_dec_valid = dec_valid;
    if (imem_rsp_valid) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
      out_m--;
    end
    if (imem_req_valid && imem_req_ready) begin
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + lat);
      acc_addr.push_back(imem_req_addr);
      acc_n++;
      out_m++;
      if (out_m > max_out) max_out = out_m;
    end
    if (dec_valid && dec_ready) begin
      pop_pc.push_back(dec_pc);
      pop_ins.push_back(dec_instr);
      pop_cyc.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_model();
    mq_addr.delete();
    mq_due.delete();
    acc_addr.delete();
    pop_pc.delete();
    pop_ins.delete();
    pop_cyc.delete();
    out_m   = 0;
    max_out = 0;
    acc_n   = 0;
    imem_rsp_valid = 1'b0;
  endtask

  task automatic clear_pops();
    pop_pc.delete();
    pop_ins.delete();
    pop_cyc.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check_eq({tag, "_dec_valid"}, 32'(dec_valid), 32'd0);
    check_eq({tag, "_req_addr"},  imem_req_addr, RESET_PC);
    check_eq({tag, "_dec_pc"},    dec_pc, 32'd0);
    check_eq({tag, "_dec_instr"}, dec_instr, 32'd0);
  endtask

  task automatic do_reset(input int latency, input logic rdy);
    rstn           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b0;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    lat       = latency;
    dec_ready = rdy;
    rstn      = 1'b1;
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  // Popped words must be base, base+4, ... each with its memory contents.
  task automatic check_seq(input string tag, input logic [31:0] base, input int n);
    logic [31:0] pc;
    check_eq({tag, "_cnt"}, 32'(pop_pc.size() >= n), 32'd1);
    for (int i = 0; i < n; i++) begin
      pc = base + 32'(4 * i);
      if (i < pop_pc.size()) begin
        check_eq($sformatf("%s_pc%0d", tag, i), pop_pc[i], pc);
        check_eq($sformatf("%s_ins%0d", tag, i), pop_ins[i], pc ^ KEY);
      end
    end
  endtask

  task automatic wait_outst(input string tag, input int target);
    for (int i = 0; i < 20 && out_m != target; i++) tick();
    check_eq(tag, 32'(out_m), 32'(target));
  endtask

  initial begin
    rstn           = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    dec_ready      = 1'b0;
    #2;
    rstn = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs("rst");

    // 1: single-cycle memory, decode always ready -> one instruction per cycle
    do_reset(1, 1'b1);
    run(16);
    check_eq("t1_first_addr", acc_addr[0], RESET_PC);
    check_eq("t1_second_addr", acc_addr[1], 32'h4);
    check_seq("t1", 32'h0, 12);
    check_eq("t1_rate", 32'(pop_cyc[11] - pop_cyc[0]), 32'd11);

    // 2: decode stalled -> exactly DEPTH requests, then drains in order
    do_reset(1, 1'b0);
    run(12);
    check_eq("t2_accepts", 32'(acc_n), 32'd4);
    check_eq("t2_req_valid", 32'(s_req_valid), 32'd0);
    check_eq("t2_dec_valid", 32'(s_dec_valid), 32'd1);
    check_eq("t2_head_pc", dec_pc, 32'h0);
    dec_ready = 1'b1;
    run(14);
    check_seq("t2", 32'h0, 8);

    // 3: three-cycle memory latency -> outstanding capped at MAX_OUTST
    do_reset(3, 1'b1);
    run(40);
    check_eq("t3_max_outst", 32'(max_out), 32'd2);
    check_seq("t3", 32'h0, 8);

    // 4: redirect with two in flight -> both dropped, decode restarts at 0x100
    do_reset(3, 1'b1);
    wait_outst("t4_outst", 2);
    pulse_redirect(32'h100);
    check_eq("t4_redir_req", 32'(s_req_valid), 32'd0);
    check_eq("t4_redir_dec", 32'(s_dec_valid), 32'd0);
    clear_pops();
    run(30);
    check_seq("t4", 32'h100, 6);
    // back-to-back redirects: the last target wins
    wait_outst("t4b_outst", 2);
    pulse_redirect(32'h200);
    pulse_redirect(32'h300);
    clear_pops();
    run(30);
    check_seq("t4b", 32'h300, 4);

    // 5: redirect to unaligned 0x103 in a cycle with a response and decode ready
    do_reset(1, 1'b1);
    run(8);
    pulse_redirect(32'h103);
    clear_pops();
    tick();
    check_eq("t5_dec_empty", 32'(s_dec_valid), 32'd0);
    check_eq("t5_req_valid", 32'(s_req_valid), 32'd1);
    check_eq("t5_req_addr", s_req_addr, 32'h100);
    run(10);
    check_seq("t5", 32'h100, 6);
    // fetch PC wraps modulo 2^32
    pulse_redirect(32'hFFFF_FFF9);
    clear_pops();
    run(12);
    check_seq("t5w", 32'hFFFF_FFF8, 4);

    // 6: asynchronous reset mid-burst -> immediate reset, refetch from RESET_PC
    do_reset(2, 1'b1);
    run(8);
    rstn = 1'b0;
    clear_model();
    #1;
    check_reset_outputs("t6");
    @(negedge clk);
    rstn = 1'b1;
    run(14);
    check_seq("t6", RESET_PC, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
